// File: rtl/geo_cross_arb.sv
// Two-requester arbiter and 2-stage shared cross-product pipeline for the geofence datapath.
// Define GEO_FIXED_PRI_EN for fixed priority (requester 1 wins ties) instead of round-robin.
module geo_cross_arb #(
   parameter int unsigned W  = 10,
   parameter int unsigned RW = 2 * W + 3
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_req0,
   input  logic                 i_req1,
   input  logic [W-1:0]         i_ox0,
   input  logic [W-1:0]         i_oy0,
   input  logic [W-1:0]         i_ax0,
   input  logic [W-1:0]         i_ay0,
   input  logic [W-1:0]         i_bx0,
   input  logic [W-1:0]         i_by0,
   input  logic [W-1:0]         i_ox1,
   input  logic [W-1:0]         i_oy1,
   input  logic [W-1:0]         i_ax1,
   input  logic [W-1:0]         i_ay1,
   input  logic [W-1:0]         i_bx1,
   input  logic [W-1:0]         i_by1,
   output logic                 o_gnt0,
   output logic                 o_gnt1,
   output logic                 o_rsp_vld0,
   output logic                 o_rsp_vld1,
   output logic signed [RW-1:0] o_rsp_val,
   output logic                 o_rsp_pos,
   output logic                 o_rsp_zero,
   output logic                 o_busy
);

   logic                   w_gnt0;
   logic                   w_gnt1;
   logic                   w_grant;
   logic [W-1:0]           w_ox, w_oy, w_ax, w_ay, w_bx, w_by;
   logic signed [W:0]      w_dax, w_day, w_dbx, w_dby;

   logic                   r_s1_vld;
   logic                   r_s1_tag;
   logic signed [W:0]      r_s1_dax, r_s1_day, r_s1_dbx, r_s1_dby;

   logic signed [2*W+1:0]  w_dax_x, w_day_x, w_dbx_x, w_dby_x;
   logic signed [2*W+1:0]  w_prod_a, w_prod_b;
   logic signed [RW-1:0]   w_prod_a_x, w_prod_b_x;
   logic signed [RW-1:0]   w_cross;

   logic                   r_s2_vld;
   logic                   r_s2_tag;
   logic signed [RW-1:0]   r_s2_cross;
   logic                   r_s2_pos;
   logic                   r_s2_zero;

`ifndef GEO_FIXED_PRI_EN
   logic                   r_last_gnt;
`endif

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!i_reset) begin
         if (i_req0 && i_req1) begin
`ifdef GEO_FIXED_PRI_EN
            w_gnt1 = 1'b1;
`else
            w_gnt1 = ~r_last_gnt;
            w_gnt0 = r_last_gnt;
`endif
         end else begin
            w_gnt0 = i_req0;
            w_gnt1 = i_req1;
         end
      end
   end

   assign w_grant = w_gnt0 | w_gnt1;
   assign o_gnt0  = w_gnt0;
   assign o_gnt1  = w_gnt1;

`ifndef GEO_FIXED_PRI_EN
   // Reset to 1 so requester 0 takes the first tie.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_last_gnt <= 1'b1;
      end else if (w_grant) begin
         r_last_gnt <= w_gnt1;
      end
   end
`endif

   always_comb begin
      w_ox = w_gnt1 ? i_ox1 : i_ox0;
      w_oy = w_gnt1 ? i_oy1 : i_oy0;
      w_ax = w_gnt1 ? i_ax1 : i_ax0;
      w_ay = w_gnt1 ? i_ay1 : i_ay0;
      w_bx = w_gnt1 ? i_bx1 : i_bx0;
      w_by = w_gnt1 ? i_by1 : i_by0;
   end

   assign w_dax = $signed({1'b0, w_ax}) - $signed({1'b0, w_ox});
   assign w_day = $signed({1'b0, w_ay}) - $signed({1'b0, w_oy});
   assign w_dbx = $signed({1'b0, w_bx}) - $signed({1'b0, w_ox});
   assign w_dby = $signed({1'b0, w_by}) - $signed({1'b0, w_oy});

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_s1_vld <= 1'b0;
         r_s1_tag <= 1'b0;
         r_s1_dax <= '0;
         r_s1_day <= '0;
         r_s1_dbx <= '0;
         r_s1_dby <= '0;
      end else begin
         r_s1_vld <= w_grant;
         if (w_grant) begin
            r_s1_tag <= w_gnt1;
            r_s1_dax <= w_dax;
            r_s1_day <= w_day;
            r_s1_dbx <= w_dbx;
            r_s1_dby <= w_dby;
         end
      end
   end

   // Widen before multiplying so the products are exact at 2W+2 bits.
   assign w_dax_x  = {{(W + 1){r_s1_dax[W]}}, r_s1_dax};
   assign w_day_x  = {{(W + 1){r_s1_day[W]}}, r_s1_day};
   assign w_dbx_x  = {{(W + 1){r_s1_dbx[W]}}, r_s1_dbx};
   assign w_dby_x  = {{(W + 1){r_s1_dby[W]}}, r_s1_dby};
   assign w_prod_a = w_dax_x * w_dby_x;
   assign w_prod_b = w_dbx_x * w_day_x;

   assign w_prod_a_x = {{(RW - 2 * W - 2){w_prod_a[2*W+1]}}, w_prod_a};
   assign w_prod_b_x = {{(RW - 2 * W - 2){w_prod_b[2*W+1]}}, w_prod_b};
   assign w_cross    = w_prod_a_x - w_prod_b_x;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_s2_vld   <= 1'b0;
         r_s2_tag   <= 1'b0;
         r_s2_cross <= '0;
         r_s2_pos   <= 1'b0;
         r_s2_zero  <= 1'b0;
      end else begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_tag   <= r_s1_tag;
            r_s2_cross <= w_cross;
            r_s2_pos   <= ~w_cross[RW-1] & (|w_cross);
            r_s2_zero  <= ~(|w_cross);
         end
      end
   end

   assign o_rsp_vld0 = r_s2_vld & ~r_s2_tag;
   assign o_rsp_vld1 = r_s2_vld & r_s2_tag;
   assign o_rsp_val  = r_s2_cross;
   assign o_rsp_pos  = r_s2_pos;
   assign o_rsp_zero = r_s2_zero;
   assign o_busy     = r_s1_vld | r_s2_vld;

endmodule

// File: tb/tb_geo_cross_arb.sv
// Directed self-checking bench for geo_cross_arb (both arbitration builds via GEO_FIXED_PRI_EN).
module tb_geo_cross_arb;

   localparam int W  = 10;
   localparam int RW = 2 * W + 3;

   logic                 clk;
   logic                 rst;
   logic                 req0, req1;
   logic [W-1:0]         ox0, oy0, ax0, ay0, bx0, by0;
   logic [W-1:0]         ox1, oy1, ax1, ay1, bx1, by1;
   logic                 gnt0, gnt1, rsp_vld0, rsp_vld1, rsp_pos, rsp_zero, busy;
   logic signed [RW-1:0] rsp_val;

   int n_total = 0;
   int n_pass  = 0;

   geo_cross_arb #(.W(W), .RW(RW)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_req0     (req0),
      .i_req1     (req1),
      .i_ox0      (ox0),
      .i_oy0      (oy0),
      .i_ax0      (ax0),
      .i_ay0      (ay0),
      .i_bx0      (bx0),
      .i_by0      (by0),
      .i_ox1      (ox1),
      .i_oy1      (oy1),
      .i_ax1      (ax1),
      .i_ay1      (ay1),
      .i_bx1      (bx1),
      .i_by1      (by1),
      .o_gnt0     (gnt0),
      .o_gnt1     (gnt1),
      .o_rsp_vld0 (rsp_vld0),
      .o_rsp_vld1 (rsp_vld1),
      .o_rsp_val  (rsp_val),
      .o_rsp_pos  (rsp_pos),
      .o_rsp_zero (rsp_zero),
      .o_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic set0(input int ox, input int oy, input int ax, input int ay,
                       input int bx, input int by);
      ox0 = W'(ox); oy0 = W'(oy); ax0 = W'(ax); ay0 = W'(ay); bx0 = W'(bx); by0 = W'(by);
   endtask

   task automatic set1(input int ox, input int oy, input int ax, input int ay,
                       input int bx, input int by);
      ox1 = W'(ox); oy1 = W'(oy); ax1 = W'(ax); ay1 = W'(ay); bx1 = W'(bx); by1 = W'(by);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single isolated operation: grant, one cycle in S1, response two cycles after grant.
   task automatic single_op(input string tag, input int r, input int ox, input int oy,
                            input int ax, input int ay, input int bx, input int by,
                            input int expv);
      tick();
      if (r == 0) begin
         set0(ox, oy, ax, ay, bx, by);
         req0 = 1'b1;
      end else begin
         set1(ox, oy, ax, ay, bx, by);
         req1 = 1'b1;
      end
      #1;
      chk({tag, " gnt0"}, 32'(gnt0), 32'(r == 0));
      chk({tag, " gnt1"}, 32'(gnt1), 32'(r == 1));
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      chk({tag, " busy n+1"}, 32'(busy), 1);
      chk({tag, " no early rsp"}, 32'(rsp_vld0 | rsp_vld1), 0);
      tick();
      chk({tag, " rsp_vld0"}, 32'(rsp_vld0), 32'(r == 0));
      chk({tag, " rsp_vld1"}, 32'(rsp_vld1), 32'(r == 1));
      chk({tag, " rsp_val"}, 32'(rsp_val), expv);
      chk({tag, " rsp_pos"}, 32'(rsp_pos), 32'(expv > 0));
      chk({tag, " rsp_zero"}, 32'(rsp_zero), 32'(expv == 0));
      tick();
      chk({tag, " rsp one cycle"}, 32'(rsp_vld0 | rsp_vld1), 0);
      chk({tag, " idle"}, 32'(busy), 0);
   endtask

   int exp_g[4];
   int exp_v[4];
   int cnt0, cnt1;

   initial begin
      rst = 1'b1;
      req0 = 1'b1;
      req1 = 1'b0;
      set0(0, 0, 0, 0, 0, 0);
      set1(0, 0, 0, 0, 0, 0);
      #1;
      chk("gnt0 in reset", 32'(gnt0), 0);
      chk("gnt1 in reset", 32'(gnt1), 0);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      chk("reset busy", 32'(busy), 0);
      chk("reset rsp_vld", 32'({rsp_vld1, rsp_vld0}), 0);
      chk("reset rsp_val", 32'(rsp_val), 0);
      chk("reset rsp_pos", 32'(rsp_pos), 0);
      chk("reset rsp_zero", 32'(rsp_zero), 0);
      #2;
      rst = 1'b0;

      single_op("req0 only", 0, 0, 0, 10, 0, 0, 10, 100);
      single_op("collinear", 0, 5, 5, 10, 10, 20, 20, 0);
      single_op("req1 only", 1, 0, 0, 0, 10, 10, 0, -100);

      // Tie for 4 cycles; last grant was requester 1, so round-robin starts with requester 0.
`ifdef GEO_FIXED_PRI_EN
      exp_g = '{1, 1, 1, 1};
`else
      exp_g = '{0, 1, 0, 1};
`endif
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i < 4) begin
            // Requester 0 op yields +(cnt0+1); requester 1 op yields -(cnt1+11).
            set0(0, 0, cnt0 + 1, 0, 0, 1);
            set1(0, 0, 0, 1, cnt1 + 11, 0);
            req0 = 1'b1;
            req1 = 1'b1;
            #1;
            chk("tie gnt0", 32'(gnt0), 32'(exp_g[i] == 0));
            chk("tie gnt1", 32'(gnt1), 32'(exp_g[i] == 1));
            if (exp_g[i] == 0) begin
               exp_v[i] = cnt0 + 1;
               cnt0++;
            end else begin
               exp_v[i] = -(cnt1 + 11);
               cnt1++;
            end
         end else begin
            req0 = 1'b0;
            req1 = 1'b0;
            #1;
         end
         if (i >= 2) begin
            chk("tie rsp_vld0", 32'(rsp_vld0), 32'(exp_g[i-2] == 0));
            chk("tie rsp_vld1", 32'(rsp_vld1), 32'(exp_g[i-2] == 1));
            chk("tie rsp_val", 32'(rsp_val), exp_v[i-2]);
         end
      end
      tick();
      tick();
      chk("tie drained", 32'(busy), 0);

      single_op("extreme pos", 0, 0, 0, 1023, 0, 0, 1023, 1046529);
      single_op("extreme neg", 1, 0, 0, 0, 1023, 1023, 0, -1046529);

      // Grant in n, reset pulsed inside n+1: the op must vanish.
      tick();
      set0(0, 0, 7, 0, 0, 7);
      req0 = 1'b1;
      #1;
      chk("pre-reset gnt0", 32'(gnt0), 1);
      tick();
      req0 = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid reset busy", 32'(busy), 0);
      #2;
      rst = 1'b0;
      tick();
      chk("no rsp after reset", 32'(rsp_vld0 | rsp_vld1), 0);
      chk("busy after reset", 32'(busy), 0);
      chk("rsp_val after reset", 32'(rsp_val), 0);
      req0 = 1'b1;
      req1 = 1'b1;
      #1;
`ifdef GEO_FIXED_PRI_EN
      chk("post-reset tie gnt0", 32'(gnt0), 0);
      chk("post-reset tie gnt1", 32'(gnt1), 1);
`else
      chk("post-reset tie gnt0", 32'(gnt0), 1);
      chk("post-reset tie gnt1", 32'(gnt1), 0);
`endif
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/geo_cross_arb.md
Name: geo_cross_arb

Overview:
- Shared cross-product engine with a two-requester arbiter for the geofence datapath.
- Requester 0 is the angular-sort engine; requester 1 is the inside-test engine. Both need cross(O,A,B) = (Ax-Ox)*(By-Oy) - (Bx-Ox)*(Ay-Oy).
- The block grants one operation per cycle, computes it in a 2-stage pipeline, and routes the tagged result back to the originating requester.
- Sits between the point register file and the two engines, so only one pair of multipliers is needed.

Parameters:
- W, 10, coordinate width (unsigned).
- RW, 2*W+3, result width (signed; holds full-range cross product without overflow).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 operation request.
- req1  in  1  requester 1 operation request.
- ox0, oy0, ax0, ay0, bx0, by0  in  W each  requester 0 operands O, A, B.
- ox1, oy1, ax1, ay1, bx1, by1  in  W each  requester 1 operands O, A, B.
- gnt0  out  1  requester 0 accepted this cycle (combinational).
- gnt1  out  1  requester 1 accepted this cycle (combinational).
- rsp_vld0  out  1  result valid for requester 0 (registered).
- rsp_vld1  out  1  result valid for requester 1 (registered).
- rsp_val  out  RW  signed cross product, shared by both requesters.
- rsp_pos  out  1  rsp_val > 0.
- rsp_zero  out  1  rsp_val == 0.
- busy  out  1  any pipeline stage valid.

Behaviour:
- Handshake:
  - A requester holds req and operands stable until it sees gnt high in the same cycle.
  - Operands are sampled at the clock edge that ends the grant cycle.
  - The requester may drop req, or present new operands, in the next cycle.
- Arbitration:
  - At most one gnt per cycle; gnt is never high without its req.
  - If only one req is high, that requester is granted.
  - If both are high, round-robin: register last_gnt. Grant requester 1 if last_gnt==0, otherwise requester 0.
  - last_gnt updates only on a grant. Reset value is 1, so requester 0 wins the first tie.
  - The block always grants when at least one req is high; no stall.
- Pipeline and latency:
  - S1 registers s1_vld, s1_tag and signed (W+1)-bit differences dax, day, dbx, dby.
  - S2 registers s2_vld, s2_tag and cross = dax*dby - dbx*day, with (2W+2)-bit products subtracted into RW bits.
  - A grant in cycle n gives rsp_vld<tag> high in cycle n+2 for exactly one cycle.
  - rsp_val, rsp_pos and rsp_zero derive from S2.
  - Back-to-back grants give back-to-back responses; throughput is 1 op per cycle.
- Results:
  - rsp_vld0 = s2_vld & ~s2_tag; rsp_vld1 = s2_vld & s2_tag.
  - rsp_val, rsp_pos and rsp_zero are don't-care when both rsp_vld are low, but deterministic: they hold the last S2 contents.
- busy = s1_vld | s2_vld.
- Reset:
  - Asserting reset at any time, including mid-operation, clears s1_vld, s2_vld, the data registers and rsp_* to 0, and sets last_gnt to 1.
  - In-flight operations are discarded and produce no response.
  - gnt0/gnt1 are 0 while reset is high.
- Boundaries:
  - Full-range operands (0 or 2^W-1) must not overflow; |cross| max is 2*(2^W-1)^2 < 2^(RW-1).
  - Degenerate input (A==O or B==O) gives rsp_zero=1.

Optional Feature:
- Macro: GEO_FIXED_PRI_EN.
- When defined, arbitration is fixed priority: requester 1 (inside-test) always wins a tie, and the last_gnt register is not built.
- When undefined, round-robin as specified above.

Test Plan:
- req0 only: O=(0,0), A=(10,0), B=(0,10) → gnt0 in cycle n; rsp_vld0 in n+2 with rsp_val=100, rsp_pos=1, rsp_zero=0.
- req1 only: O=(0,0), A=(0,10), B=(10,0) → rsp_vld1 in n+2 with rsp_val=-100, rsp_pos=0, rsp_zero=0.
- Collinear via req0: O=(5,5), A=(10,10), B=(20,20) → rsp_val=0, rsp_zero=1.
- Both req held 4 cycles → grants alternate 0,1,0,1 (GEO_FIXED_PRI_EN: 1,1,1,1); responses arrive 2 cycles later with matching tags and no gaps.
- Extremes: O=(0,0), A=(1023,0), B=(0,1023) → rsp_val=1046529. Swapped A and B → rsp_val=-1046529.
- Grant in cycle n, reset pulsed in n+1 → no rsp_vld in n+2; busy=0 after reset; the next tie is granted to requester 0.
